// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state
// encoding, default text-segment base address and the PC alignment mask.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0040_0000;

  // Low PC bits that must be zero for a word-aligned instruction fetch.
  localparam logic [1:0]  PC_ALIGN_MASK     = 2'b11;

endpackage

// File: rtl/fetch_out_buf.sv
// Output buffer for fetched instructions: holds the instruction word, its
// PC and a valid flag. Priority is clear > load > accept.
module fetch_out_buf #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [31:0] RST_PC = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] pc_d,
  output logic              valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] pc
);

  // Buffer register: load a new word, drop it on flush or when decode takes it.
  // NOTE: the data fields are reset as well as the valid flag, so inst_pc
  // shows the text-segment base and inst_out shows zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= RST_PC[ADDR_W-1:0];
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= din;
      pc    <= pc_d;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: reads imem at the current PC, buffers the
// word for decode and pulses pc_ena once per accepted fetch.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt outputs.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          IMEM_AW   = 11,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_ena,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [DATA_W-1:0]  imem_rdata,
  input  logic               flush,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [DATA_W-1:0]  inst_out,
  output logic [ADDR_W-1:0]  inst_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
`endif
  output logic               fetch_err
);

  fetch_state_t      state, state_nxt;
  logic              misaligned;
  logic              buf_load, buf_clear, buf_accept;
  logic              err_set, err_clr;
  logic [ADDR_W-1:0] pc_off;

  // Word address relative to the text segment, truncated to the imem size.
  assign pc_off     = pc_in - BASE_ADDR[ADDR_W-1:0];
  assign imem_addr  = pc_off[IMEM_AW+1:2];
  assign misaligned = (pc_in[1:0] & PC_ALIGN_MASK) != 2'b00;
  assign buf_accept = inst_valid & inst_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; flush overrides everything but reset.
  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pc_ena    = 1'b0;
    imem_req  = 1'b0;
    buf_load  = 1'b0;
    buf_clear = flush;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = !misaligned;
        if (flush) begin
          // A request was in flight only if the PC was aligned; if it was
          // acked this same cycle the data is simply dropped.
          state_nxt = (misaligned || imem_ack) ? REQ : DRAIN;
        end else if (misaligned) begin
          err_set   = 1'b1;
          state_nxt = ERR;
        end else if (imem_ack) begin
          pc_ena    = 1'b1;
          buf_load  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_nxt = REQ;
      end
      DRAIN: begin
        if (flush || imem_ack) state_nxt = REQ;
      end
      ERR: begin
        if (flush) begin
          err_clr   = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky misalignment flag, cleared only by the flush that leaves ERR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fetch_err <= 1'b0;
    else if (err_set) fetch_err <= 1'b1;
    else if (err_clr) fetch_err <= 1'b0;
  end

  fetch_out_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RST_PC (BASE_ADDR)
  ) u_out_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .clear  (buf_clear),
    .accept (buf_accept),
    .din    (imem_rdata),
    .pc_d   (pc_in),
    .valid  (inst_valid),
    .inst   (inst_out),
    .pc     (inst_pc)
  );

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: delivered instructions and REQ cycles without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (buf_accept)                 fetch_cnt <= fetch_cnt + 32'd1;
      if (state == REQ && !imem_ack)  stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl. The bench plays the
// PC register by hand: it updates pc_in after each expected pc_ena pulse.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = BASE;
  logic        pc_ena;
  logic        imem_req;
  logic [10:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int pc_ena_cnt = 0;

  inst_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_ena     (pc_ena),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Count pc_ena pulses as the PC register would see them at each edge.
  always @(posedge clk) if (pc_ena === 1'b1) pc_ena_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_pc_ena",   pc_ena, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_valid",    inst_valid, 0);
    check("rst_err",      fetch_err, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc",  inst_pc, BASE);
    rst = 1'b0;                     // released mid-cycle, before the 15 ns edge

    // Test 1: IDLE -> REQ, 1-cycle ack
    step();
    check("t1_req",  imem_req, 1);
    check("t1_addr", imem_addr, 0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    #1;
    check("t1_pc_ena", pc_ena, 1);
    step();                         // HOLD
    imem_ack = 1'b0;
    pc_in    = 32'h0040_0004;       // PC register advanced by the pulse
    check("t1_valid",    inst_valid, 1);
    check("t1_inst_out", inst_out, 32'h2008_0005);
    check("t1_inst_pc",  inst_pc, 32'h0040_0000);
    check("t1_pc_ena_n", pc_ena_cnt, 1);

    // Test 2: decode stalls 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", inst_valid, 1);
      check("t2_hold_pcena", pc_ena, 0);
      check("t2_hold_req",   imem_req, 0);
    end
    inst_ready = 1'b1;
    step();                         // REQ at 0x00400004
    inst_ready = 1'b0;
    check("t2_req",   imem_req, 1);
    check("t2_addr",  imem_addr, 1);
    check("t2_valid", inst_valid, 0);
    check("t2_pc_ena_n", pc_ena_cnt, 1);

    // Test 3: ack delayed, arriving in the third REQ cycle
    imem_rdata = 32'h8C09_0000;
    step();
    check("t3_req_c2",  imem_req, 1);
    check("t3_addr_c2", imem_addr, 1);
    check("t3_pcena_c2", pc_ena, 0);
    step();
    imem_ack = 1'b1;
    #1;
    check("t3_req_c3",  imem_req, 1);
    check("t3_addr_c3", imem_addr, 1);
    check("t3_pcena_c3", pc_ena, 1);
    step();                         // HOLD
    imem_ack = 1'b0;
    check("t3_pc_ena_n", pc_ena_cnt, 2);
    check("t3_inst_out", inst_out, 32'h8C09_0000);
    check("t3_inst_pc",  inst_pc, 32'h0040_0004);
`ifdef FETCH_PERF_CNT_EN
    check("t3_stall_cnt", stall_cnt, 2);
    check("t3_fetch_cnt", fetch_cnt, 1);
`endif
    pc_in      = 32'h0040_0008;
    inst_ready = 1'b1;
    step();                         // REQ at 0x00400008
    inst_ready = 1'b0;
    check("t3_req_next", imem_req, 1);
    check("t3_addr_next", imem_addr, 2);

    // Test 4: flush in REQ before ack, ack arrives 2 cycles later
    flush = 1'b1;
    pc_in = 32'h0040_0100;          // redirect loads the PC in the flush cycle
    #1;
    check("t4_flush_pcena", pc_ena, 0);
    step();                         // DRAIN
    flush = 1'b0;
    check("t4_drain_req",   imem_req, 0);
    check("t4_drain_valid", inst_valid, 0);
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t4_drain_ack_pcena", pc_ena, 0);
    check("t4_drain_ack_req",   imem_req, 0);
    step();                         // REQ at redirected PC
    imem_ack = 1'b0;
    check("t4_req",      imem_req, 1);
    check("t4_addr",     imem_addr, 11'h40);
    check("t4_valid",    inst_valid, 0);
    check("t4_inst_out", inst_out, 32'h8C09_0000);
    check("t4_pc_ena_n", pc_ena_cnt, 2);

    // Test 5: misaligned PC -> ERR, recover with flush
    pc_in = 32'h0040_0102;
    #1;
    check("t5_req_drop", imem_req, 0);
    check("t5_pcena",    pc_ena, 0);
    step();                         // ERR
    check("t5_err",     fetch_err, 1);
    check("t5_err_req", imem_req, 0);
    imem_ack = 1'b1;
    step();
    step();
    check("t5_err_sticky", fetch_err, 1);
    check("t5_err_req2",   imem_req, 0);
    check("t5_err_pcena",  pc_ena, 0);
    check("t5_err_valid",  inst_valid, 0);
    imem_ack = 1'b0;
    flush = 1'b1;
    pc_in = 32'h0040_0200;
    step();                         // REQ
    flush = 1'b0;
    check("t5_err_clr", fetch_err, 0);
    check("t5_req",     imem_req, 1);
    check("t5_addr",    imem_addr, 11'h80);
    check("t5_pc_ena_n", pc_ena_cnt, 2);

    // Test 6: async reset mid-REQ, then a late ack
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_req",   imem_req, 0);
    check("t6_rst_pcena", pc_ena, 0);
    check("t6_rst_valid", inst_valid, 0);
    check("t6_rst_err",   fetch_err, 0);
    check("t6_rst_out",   inst_out, 0);
    check("t6_rst_pc",    inst_pc, BASE);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();                         // edge under reset
    rst = 1'b0;                     // IDLE, late ack still high
    #1;
    check("t6_idle_pcena", pc_ena, 0);
    check("t6_idle_req",   imem_req, 0);
    imem_ack = 1'b0;
    step();                         // REQ
    check("t6_valid",     inst_valid, 0);
    check("t6_req",       imem_req, 1);
    check("t6_pc_ena_n",  pc_ena_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
